// File: rtl/ch2_regs_timer.sv
// ch2_regs_timer: NR21-NR24 register block and 11-bit frequency timer for channel 2.
// Define CH2_READBACK_EN to build the CPU read decode; otherwise d_out reads FFh.
`timescale 1ns/1ps
module ch2_regs_timer (
    input  logic       amuk_4mhz,
    input  logic       napu_reset,
    input  logic       apu_en,
    input  logic [7:0] a,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    input  logic       nch2_active,
    output logic       nff16_wr,
    output logic       ff16_d6,
    output logic       nff16_d6,
    output logic       ff16_d7,
    output logic       nff16_d7,
    output logic [7:0] ff17_d,
    output logic       nff17_d0,
    output logic       nff17_d1,
    output logic       nff17_d2,
    output logic       nff17_d3,
    output logic       ff19_d6,
    output logic       nff19_d6,
    output logic       ff19_d7,
    output logic       ch2_ftick
);

    logic [1:0]  duty;
    logic [7:0]  nr22;
    logic [7:0]  freq_lo;
    logic [2:0]  freq_hi;
    logic        len_en;
    logic [10:0] timer;
    logic [1:0]  presc;
    logic [2:0]  trig_cnt;
    logic        wr16_n;
    logic        ftick;

    logic        clr;
    logic        wr16;
    logic        wr17;
    logic        wr18;
    logic        wr19;
    logic        trig;
    logic        tick1m;
    logic        run;
    logic [10:0] freq;

    assign clr    = ~napu_reset | ~apu_en;
    assign wr16   = cpu_wr & apu_en & (a == 8'h16);
    assign wr17   = cpu_wr & apu_en & (a == 8'h17);
    assign wr18   = cpu_wr & apu_en & (a == 8'h18);
    assign wr19   = cpu_wr & apu_en & (a == 8'h19);
    assign trig   = wr19 & d_in[7];
    assign tick1m = (presc == 2'd3);
    assign run    = tick1m & (~nch2_active | (trig_cnt != 3'd0));
    assign freq   = {freq_hi, freq_lo};

    // CPU-written register bits; cleared while the APU is off
    always_ff @(posedge amuk_4mhz) begin
        if (clr) begin
            duty    <= 2'd0;
            nr22    <= 8'd0;
            freq_lo <= 8'd0;
            freq_hi <= 3'd0;
            len_en  <= 1'b0;
        end else begin
            if (wr16) duty <= d_in[7:6];
            if (wr17) nr22 <= d_in;
            if (wr18) freq_lo <= d_in;
            if (wr19) begin
                freq_hi <= d_in[2:0];
                len_en  <= d_in[6];
            end
        end
    end

    // Trigger stretcher: restarts at 4 on every trigger write
    always_ff @(posedge amuk_4mhz) begin
        if (clr)
            trig_cnt <= 3'd0;
        else if (trig)
            trig_cnt <= 3'd4;
        else if (trig_cnt != 3'd0)
            trig_cnt <= trig_cnt - 3'd1;
    end

    // Prescaler and frequency timer; a trigger reload beats an overflow
    always_ff @(posedge amuk_4mhz) begin
        if (clr) begin
            presc <= 2'd0;
            timer <= 11'd0;
            ftick <= 1'b0;
        end else begin
            presc <= presc + 2'd1;
            ftick <= 1'b0;
            if (trig) begin
                timer <= {d_in[2:0], freq_lo};
            end else if (run) begin
                if (timer == 11'h7FF) begin
                    timer <= freq;
                    ftick <= 1'b1;
                end else begin
                    timer <= timer + 11'd1;
                end
            end
        end
    end

    // One-clock active-low NR21 write strobe
    always_ff @(posedge amuk_4mhz) begin
        if (clr)
            wr16_n <= 1'b1;
        else
            wr16_n <= ~wr16;
    end

    assign nff16_wr  = wr16_n;
    assign ff16_d6   = duty[0];
    assign nff16_d6  = ~duty[0];
    assign ff16_d7   = duty[1];
    assign nff16_d7  = ~duty[1];
    assign ff17_d    = nr22;
    assign nff17_d0  = ~nr22[0];
    assign nff17_d1  = ~nr22[1];
    assign nff17_d2  = ~nr22[2];
    assign nff17_d3  = ~nr22[3];
    assign ff19_d6   = len_en;
    assign nff19_d6  = ~len_en;
    assign ff19_d7   = (trig_cnt != 3'd0);
    assign ch2_ftick = ftick;

`ifdef CH2_READBACK_EN
    // Read mux: write-only bits read back as 1
    always_comb begin
        d_out = 8'hFF;
        if (cpu_rd) begin
            unique case (a)
                8'h16:   d_out = {duty, 6'h3F};
                8'h17:   d_out = nr22;
                8'h19:   d_out = {1'b1, len_en, 6'h3F};
                default: d_out = 8'hFF;
            endcase
        end
    end
`else
    logic unused_rd;
    assign unused_rd = cpu_rd;
    assign d_out     = 8'hFF;
`endif

endmodule

// File: tb/tb_ch2_regs_timer.sv
// tb_ch2_regs_timer: table vectors, timing sequences and a random run
// checked against a cycle-count model of the channel 2 register block.
`timescale 1ns/1ps
module tb_ch2_regs_timer;

    logic       clk = 1'b0;
    logic       napu_reset;
    logic       apu_en;
    logic [7:0] a;
    logic       cpu_wr;
    logic       cpu_rd;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       nch2_active;
    logic       nff16_wr;
    logic       ff16_d6, nff16_d6, ff16_d7, nff16_d7;
    logic [7:0] ff17_d;
    logic       nff17_d0, nff17_d1, nff17_d2, nff17_d3;
    logic       ff19_d6, nff19_d6, ff19_d7;
    logic       ch2_ftick;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ch2_regs_timer dut (
        .amuk_4mhz  (clk),
        .napu_reset (napu_reset),
        .apu_en     (apu_en),
        .a          (a),
        .cpu_wr     (cpu_wr),
        .cpu_rd     (cpu_rd),
        .d_in       (d_in),
        .d_out      (d_out),
        .nch2_active(nch2_active),
        .nff16_wr   (nff16_wr),
        .ff16_d6    (ff16_d6),
        .nff16_d6   (nff16_d6),
        .ff16_d7    (ff16_d7),
        .nff16_d7   (nff16_d7),
        .ff17_d     (ff17_d),
        .nff17_d0   (nff17_d0),
        .nff17_d1   (nff17_d1),
        .nff17_d2   (nff17_d2),
        .nff17_d3   (nff17_d3),
        .ff19_d6    (ff19_d6),
        .nff19_d6   (nff19_d6),
        .ff19_d7    (ff19_d7),
        .ch2_ftick  (ch2_ftick)
    );

    // Reference model: register values, 1 MHz steps left until overflow,
    // clocks since enable (mod 4), and trigger clocks remaining.
    logic [1:0] m_duty;
    logic [7:0] m_nr22;
    logic [7:0] m_flo;
    logic [2:0] m_fhi;
    logic       m_len;
    int         m_steps;
    int         m_phase;
    int         m_trig;
    logic       m_stb;
    logic       m_ftick;

    function automatic logic [7:0] m_read();
        logic [7:0] r;
        r = 8'hFF;
`ifdef CH2_READBACK_EN
        if (cpu_rd) begin
            if (a == 8'h16) r = {m_duty, 6'h3F};
            if (a == 8'h17) r = m_nr22;
            if (a == 8'h19) r = {1'b1, m_len, 6'h3F};
        end
`endif
        return r;
    endfunction

    task automatic model_clock();
        logic trg;
        int f_old;
        int f_new;
        if (!napu_reset || !apu_en) begin
            m_duty = 0; m_nr22 = 0; m_flo = 0; m_fhi = 0; m_len = 0;
            m_steps = 2048; m_phase = 0; m_trig = 0;
            m_stb = 0; m_ftick = 0;
        end else begin
            trg = cpu_wr && (a == 8'h19) && d_in[7];
            f_old = m_fhi * 256 + m_flo;
            f_new = d_in[2:0] * 256 + m_flo;
            m_ftick = 0;
            if (trg) begin
                m_steps = 2048 - f_new;
            end else if (m_phase == 3 && (!nch2_active || m_trig > 0)) begin
                m_steps = m_steps - 1;
                if (m_steps == 0) begin
                    m_ftick = 1;
                    m_steps = 2048 - f_old;
                end
            end
            m_trig = trg ? 4 : (m_trig > 0 ? m_trig - 1 : 0);
            m_phase = (m_phase + 1) % 4;
            m_stb = cpu_wr && (a == 8'h16);
            if (cpu_wr) begin
                if (a == 8'h16) m_duty = d_in[7:6];
                if (a == 8'h17) m_nr22 = d_in;
                if (a == 8'h18) m_flo = d_in;
                if (a == 8'h19) begin
                    m_fhi = d_in[2:0];
                    m_len = d_in[6];
                end
            end
        end
    endtask

    function automatic logic [20:0] act_out();
        return {nff16_wr, ff16_d6, nff16_d6, ff16_d7, nff16_d7, ff17_d,
                nff17_d0, nff17_d1, nff17_d2, nff17_d3,
                ff19_d6, nff19_d6, ff19_d7, ch2_ftick};
    endfunction

    function automatic logic [20:0] exp_out();
        return {~m_stb, m_duty[0], ~m_duty[0], m_duty[1], ~m_duty[1], m_nr22,
                ~m_nr22[0], ~m_nr22[1], ~m_nr22[2], ~m_nr22[3],
                m_len, ~m_len, (m_trig != 0), m_ftick};
    endfunction

    // One clock: check read data, advance model, check registered outputs
    task automatic step(input string tag);
        logic [7:0] er;
        #1;
        er = m_read();
        checks++;
        if (d_out !== er) begin
            failures++;
            $display("FAIL %s d_out got=%h want=%h", tag, d_out, er);
        end
        model_clock();
        @(posedge clk);
        #1;
        checks++;
        if (act_out() !== exp_out()) begin
            failures++;
            $display("FAIL %s outputs got=%h want=%h", tag, act_out(), exp_out());
        end
    endtask

    task automatic idle();
        cpu_wr = 0;
        cpu_rd = 0;
        a = 8'h00;
        d_in = 8'h00;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        cpu_wr = 1;
        a = addr;
        d_in = data;
        step("write");
        idle();
    endtask

    task automatic wait_tick(input int bound, output int n);
        n = 0;
        for (int i = 0; i < bound; i++) begin
            step("wait");
            n++;
            if (ch2_ftick) return;
        end
        checks++;
        failures++;
        $display("FAIL tick_timeout got=none want=tick within %0d", bound);
        n = -1;
    endtask

    typedef struct {
        logic       rst_n;
        logic       apu;
        logic       w;
        logic       r;
        logic [7:0] ad;
        logic [7:0] dd;
        logic [7:0] e_dout;
        logic       e_nwr;
        logic [1:0] e_duty;
        logic [7:0] e_nr22;
        logic       e_len;
        logic       e_d7;
    } vec_t;

    function automatic vec_t mk(
        logic rst_n, logic apu, logic w, logic r,
        logic [7:0] ad, logic [7:0] dd, logic [7:0] e_dout,
        logic e_nwr, logic [1:0] e_duty, logic [7:0] e_nr22,
        logic e_len, logic e_d7);
        vec_t v;
        v.rst_n = rst_n; v.apu = apu; v.w = w; v.r = r;
        v.ad = ad; v.dd = dd; v.e_dout = e_dout;
        v.e_nwr = e_nwr; v.e_duty = e_duty; v.e_nr22 = e_nr22;
        v.e_len = e_len; v.e_d7 = e_d7;
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        int n;
        int hi;
        int cnt;
        logic [7:0] ed;
        logic [12:0] got;
        logic [12:0] want;

        //            rst apu wr rd  a      d      dout   nwr dty nr22  len d7
        tbl[0]  = mk(0, 1, 0, 0, 8'h19, 8'h00, 8'hFF, 1, 0, 8'h00, 0, 0);
        tbl[1]  = mk(0, 1, 0, 1, 8'h19, 8'h00, 8'hBF, 1, 0, 8'h00, 0, 0);
        tbl[2]  = mk(1, 1, 1, 1, 8'h16, 8'hC5, 8'h3F, 0, 3, 8'h00, 0, 0);
        tbl[3]  = mk(1, 1, 0, 1, 8'h16, 8'h00, 8'hFF, 1, 3, 8'h00, 0, 0);
        tbl[4]  = mk(1, 1, 1, 1, 8'h17, 8'hF3, 8'h00, 1, 3, 8'hF3, 0, 0);
        tbl[5]  = mk(1, 1, 0, 1, 8'h17, 8'h00, 8'hF3, 1, 3, 8'hF3, 0, 0);
        tbl[6]  = mk(1, 1, 1, 1, 8'h19, 8'h40, 8'hBF, 1, 3, 8'hF3, 1, 0);
        tbl[7]  = mk(1, 1, 0, 1, 8'h19, 8'h00, 8'hFF, 1, 3, 8'hF3, 1, 0);
        tbl[8]  = mk(1, 1, 1, 1, 8'h18, 8'hFE, 8'hFF, 1, 3, 8'hF3, 1, 0);
        tbl[9]  = mk(1, 1, 1, 1, 8'h19, 8'h87, 8'hFF, 1, 3, 8'hF3, 0, 1);
        tbl[10] = mk(1, 1, 0, 1, 8'h19, 8'h00, 8'hBF, 1, 3, 8'hF3, 0, 1);
        tbl[11] = mk(1, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 1, 3, 8'hF3, 0, 1);
        tbl[12] = mk(1, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 1, 3, 8'hF3, 0, 1);
        tbl[13] = mk(1, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 1, 3, 8'hF3, 0, 0);
        tbl[14] = mk(1, 0, 1, 0, 8'h17, 8'hF3, 8'hFF, 1, 0, 8'h00, 0, 0);
        tbl[15] = mk(1, 0, 1, 1, 8'h17, 8'hF3, 8'h00, 1, 0, 8'h00, 0, 0);
        tbl[16] = mk(1, 1, 1, 1, 8'h17, 8'hF3, 8'h00, 1, 0, 8'hF3, 0, 0);
        tbl[17] = mk(1, 1, 0, 1, 8'h16, 8'h00, 8'h3F, 1, 0, 8'hF3, 0, 0);

        napu_reset = 0;
        apu_en = 1;
        nch2_active = 1;
        idle();
        m_duty = 0; m_nr22 = 0; m_flo = 0; m_fhi = 0; m_len = 0;
        m_steps = 2048; m_phase = 0; m_trig = 0; m_stb = 0; m_ftick = 0;

        for (int i = 0; i < 18; i++) begin
            napu_reset = tbl[i].rst_n;
            apu_en = tbl[i].apu;
            cpu_wr = tbl[i].w;
            cpu_rd = tbl[i].r;
            a = tbl[i].ad;
            d_in = tbl[i].dd;
            #1;
`ifdef CH2_READBACK_EN
            ed = tbl[i].e_dout;
`else
            ed = 8'hFF;
`endif
            checks++;
            if (d_out !== ed) begin
                failures++;
                $display("FAIL vec%0d_read got=%h want=%h", i, d_out, ed);
            end
            step("vec");
            got = {nff16_wr, ff16_d7, ff16_d6, ff17_d, ff19_d6, ff19_d7};
            want = {tbl[i].e_nwr, tbl[i].e_duty, tbl[i].e_nr22,
                    tbl[i].e_len, tbl[i].e_d7};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL vec%0d_regs got=%h want=%h", i, got, want);
            end
        end

        // f=7FEh: trigger width and 8-clock period
        idle();
        nch2_active = 0;
        wr(8'h18, 8'hFE);
        wr(8'h19, 8'h87);
        cnt = ff19_d7 ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            step("trig");
            if (ff19_d7) cnt++;
        end
        checks++;
        if (cnt != 4) begin
            failures++;
            $display("FAIL trig_width got=%0d want=4", cnt);
        end
        wait_tick(20, n);
        wait_tick(20, n);
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL period_7fe got=%0d want=8", n);
        end

        // Mid-period write to freq_lo only takes effect at next reload
        wr(8'h18, 8'h00);
        hi = 1;
        wait_tick(20, n);
        checks++;
        if (hi + n != 8) begin
            failures++;
            $display("FAIL period_mid_write got=%0d want=8", hi + n);
        end
        wait_tick(1100, n);
        checks++;
        if (n != 1024) begin
            failures++;
            $display("FAIL period_700 got=%0d want=1024", n);
        end

        // Silent channel freezes the timer until a trigger
        nch2_active = 1;
        wr(8'h18, 8'hFF);
        wr(8'h19, 8'h87);
        for (int i = 0; i < 8; i++) step("settle");
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step("frozen");
            if (ch2_ftick) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            failures++;
            $display("FAIL frozen_ticks got=%0d want=0", cnt);
        end
        wr(8'h19, 8'h87);
        nch2_active = 0;
        wait_tick(20, n);
        checks++;
        if (n < 1) begin
            failures++;
            $display("FAIL resume got=%0d want=tick", n);
        end

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            napu_reset = ($urandom_range(0, 299) != 0);
            apu_en = ($urandom_range(0, 149) != 0);
            cpu_wr = ($urandom_range(0, 3) == 0);
            cpu_rd = $urandom_range(0, 1);
            a = 8'h15 + 8'($urandom_range(0, 5));
            d_in = 8'($urandom);
            if (a == 8'h18) d_in[7:4] = 4'hF;
            if (a == 8'h19) begin
                d_in[2:0] = 3'h7;
                d_in[7] = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 49) == 0) nch2_active = ~nch2_active;
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ch2_regs_timer.md
# ch2_regs_timer

Bus-side register block and frequency timer for sound channel 2. It decodes CPU writes and reads to NR21–NR24 (FF16–FF19) and holds the register bits that `channel2` consumes. It generates the NR21 write strobe and the trigger pulse. It also runs the 11-bit frequency timer that produces `ch2_ftick`. It sits between the CPU data bus and `channel2`, and drives that block's register, strobe and tick inputs.

## Interface
Parameters:
- none

Ports:
- `amuk_4mhz`  in  1  system clock; all state changes on its rising edge
- `napu_reset`  in  1  reset, synchronous and active-low
- `apu_en`  in  1  NR52 bit 7; while 0 the block holds its reset state and ignores writes
- `a`  in  8  low address byte (FF page offset)
- `cpu_wr`  in  1  write qualifier, sampled each clock
- `cpu_rd`  in  1  read qualifier
- `d_in`  in  8  write data
- `d_out`  out  8  read data, combinational
- `nch2_active`  in  1  from `channel2`; 1 = channel silent, and the timer holds
- `nff16_wr`  out  1  active-low NR21 write strobe, one clock
- `ff16_d6`, `nff16_d6`, `ff16_d7`, `nff16_d7`  out  1  duty bits and their complements
- `ff17_d[7:0]`  out  8  NR22 (volume/direction/sweep); complements of d0–d3 are also output as `nff17_d0..3`
- `ff19_d6`, `nff19_d6`  out  1  length enable and its complement
- `ff19_d7`  out  1  trigger pulse
- `ch2_ftick`  out  1  frequency-timer overflow tick, one clock

## Operation
- Registers:
  - duty[1:0] (NR21 b7:6)
  - NR22[7:0]
  - freq_lo[7:0] (NR23)
  - freq_hi[2:0] (NR24 b2:0)
  - len_en (NR24 b6)
  - timer[10:0]
  - presc[1:0]
  - trig_cnt[2:0]
- Reset value of all registers is 0. Output reset values:
  - `nff16_wr`=1
  - `ff19_d7`=0
  - `ch2_ftick`=0
  - every `n*` complement output = 1
- Write: `cpu_wr`=1, `apu_en`=1 and `a` ∈ {16h,17h,18h,19h} updates the addressed register at the clock edge.
  - A write to 16h also drives `nff16_wr`=0 for the next cycle. Length bits are not stored; `channel2` loads them from the bus.
- Trigger: a write to 19h with `d_in[7]`=1:
  - loads trig_cnt=4; `ff19_d7`=1 while trig_cnt≠0, and trig_cnt decrements each clock;
  - reloads timer with {freq_hi,freq_lo}, using the newly written freq_hi;
  - leaves presc unchanged.
- Prescaler: presc increments every clock while `apu_en`=1. The 1 MHz enable `tick1m` is true when presc=3.
- Timer: on `tick1m`, when (`nch2_active`=0 or trig_cnt≠0):
  - if timer=7FFh → reload {freq_hi,freq_lo} and assert `ch2_ftick` for the following single clock;
  - otherwise timer+1.
  - Arithmetic is 11-bit unsigned and never wraps through 0.
- Read (`cpu_rd`=1), ORed with fixed masks:
  - 16h → {duty,6'h3F}
  - 17h → NR22
  - 18h → FFh
  - 19h → {1,len_en,6'h3F}
  - any other address → FFh
  - with `cpu_rd`=0 → FFh
- `apu_en`=0:
  - every register is cleared synchronously, as for reset;
  - writes are ignored; reads return the masks alone (16h→3Fh, 19h→BFh, 17h→00h).

## Timing
- Register outputs change one clock after the write edge. `d_out` follows `a` and state with no latency.
- Tick period = (2048−f)×4 clocks, with f = {freq_hi,freq_lo}. f=7FFh gives a tick every 4 clocks; f=0 gives a tick every 8192 clocks.
- A frequency write mid-period has no effect until the next reload (overflow or trigger).
- Overflow and trigger in the same cycle: the trigger reload wins and no `ch2_ftick` is issued.
- Write to 18h/19h on an overflow edge: the reload uses the pre-write value.
- Retrigger while trig_cnt≠0: trig_cnt restarts at 4, and `ff19_d7` stays high with no gap.
- Reset or `apu_en` falling mid-trigger: `ff19_d7` drops on the next edge.

## Configuration
- `CH2_READBACK_EN`:
  - defined → reads behave as described above;
  - undefined → `d_out` is constantly FFh, and the read decode logic is not built.
- Writes, the timer and all outputs are identical in both builds.

## Test plan
- Reset with `napu_reset`=0 for 2 clocks → all data outputs 0, `nff16_wr`=1, and 19h reads BFh.
- Write 16h=C5h → `nff16_wr` low for exactly 1 clock; `ff16_d7`=`ff16_d6`=1; 16h reads FFh.
- Write 18h=FEh, then 19h=87h (f=7FEh) → `ff19_d7` high for 4 clocks; `ch2_ftick` every 8 clocks; `len_en`=0.
- Run with f=7FEh, then write 18h=00h mid-period → the current period completes at 8 clocks; the next gap is (2048−1792)×4=1024 clocks.
- Hold `nch2_active`=1 with no trigger → no `ch2_ftick` and the timer is frozen. Trigger → ticks resume.
- Drive `apu_en`=0, write 17h=F3h → ignored; 17h reads 00h. Set `apu_en`=1 → the write takes effect, and `nff17_d0`=0.
